// File: rtl/line_packer.sv
// Packs a raster pixel stream into full-line words. A completed line goes straight
// to the output register when it is free, otherwise it waits in the assembly buffer (FULL).
module line_packer #(
   parameter int WIDTH = 640,
   parameter int PIX_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PIX_W-1:0]       pix_data,
   input  logic                   pix_valid,
   input  logic                   pix_sol,
   output logic                   pix_ready,
   output logic [WIDTH*PIX_W-1:0] row_pixel,
   output logic                   row_valid,
   input  logic                   row_ready,
   output logic [9:0]             row_index,
   output logic                   short_line
);
   localparam int ROW_W = WIDTH * PIX_W;
   localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);

   logic [CW-1:0]    col_q, col_d, wr_col;
   logic [ROW_W-1:0] asm_q, line_d;
   logic             full_q;
   logic [ROW_W-1:0] row_q;
   logic             row_valid_q;
   logic [9:0]       idx_q, next_idx_q;
   logic             short_q;
   logic             accept, complete, out_free, load_new, load_held;

   assign pix_ready  = !full_q;
   assign accept     = pix_valid && !full_q;
   assign wr_col     = pix_sol ? '0 : col_q;
   assign complete   = accept && (wr_col == LAST_COL);
   assign out_free   = !row_valid_q || row_ready;
   assign load_new   = complete && out_free;
   assign load_held  = full_q && out_free;
   assign col_d      = complete ? '0 : wr_col + 1'b1;

   // line_d is the assembly buffer with this cycle's pixel already merged in,
   // so a line that completes now can be loaded into the output in one edge.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_col
         logic hit;
         assign hit = accept && (wr_col == CW'(gi));
         assign line_d[PIX_W*gi +: PIX_W] = hit ? pix_data : asm_q[PIX_W*gi +: PIX_W];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q       <= '0;
         asm_q       <= '0;
         full_q      <= 1'b0;
         row_q       <= '0;
         row_valid_q <= 1'b0;
         idx_q       <= '0;
         next_idx_q  <= '0;
         short_q     <= 1'b0;
      end else begin
         if (accept) begin
            asm_q <= line_d;
            col_q <= col_d;
         end
         if (accept && pix_sol && (col_q != '0))
            short_q <= 1'b1;

         // load_held and load_new are exclusive: FULL blocks pixel acceptance.
         if (load_held || load_new) begin
            row_q       <= load_held ? asm_q : line_d;
            row_valid_q <= 1'b1;
            idx_q       <= next_idx_q;
            next_idx_q  <= next_idx_q + 10'd1;
         end else if (row_ready) begin
            row_valid_q <= 1'b0;
         end

         if (complete && !out_free)
            full_q <= 1'b1;
         else if (load_held)
            full_q <= 1'b0;
      end
   end

   assign row_pixel  = row_q;
   assign row_valid  = row_valid_q;
   assign row_index  = idx_q;
   assign short_line = short_q;

endmodule
